// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Handshake and data bundle for alu_pipe.
//                Input side:  in_valid/in_ready, alufn, ra, rb_or_imm, apb_op
//                Output side: out_valid/out_ready, aluout, br, apb_req,
//                             zf, cf, vf
//                master = operation producer / result consumer
//                slave  = the ALU pipeline
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   alufn;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb_or_imm;
  logic             apb_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluout;
  logic             br;
  logic             apb_req;
  logic             zf;
  logic             cf;
  logic             vf;

  modport master (
    output in_valid, alufn, ra, rb_or_imm, apb_op, out_ready,
    input  in_ready, out_valid, aluout, br, apb_req, zf, cf, vf
  );

  modport slave (
    input  in_valid, alufn, ra, rb_or_imm, apb_op, out_ready,
    output in_ready, out_valid, aluout, br, apb_req, zf, cf, vf
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshake and full
//                output backpressure. Stage 1 captures the operation, stage 2
//                holds the computed result and flags and drives the outputs.
//                With apb_op set, the ADD datapath produces an APB transfer
//                address and apb_req is raised.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - alu_pipe_if.slave (operation in, result out)
//  Parameters  : WIDTH - operand/result width (>= 4)
//                OPW   - opcode width (encodings live in the low 3 bits)
//  Options     : ALU_SAT_EN - signed saturation for ADD, ADDI and SUB
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic        clk,
  input  logic        rst,
  alu_pipe_if.slave   bus
);

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_sub  = 3'b001;
  localparam logic [2:0] c_op_and  = 3'b010;
  localparam logic [2:0] c_op_or   = 3'b011;
  localparam logic [2:0] c_op_addi = 3'b100;
  localparam logic [2:0] c_op_lw   = 3'b101;
  localparam logic [2:0] c_op_sw   = 3'b110;
  localparam logic [2:0] c_op_beq  = 3'b111;

  localparam int c_msb = WIDTH - 1;

  // ---------------------------------------------------------------- stage 1
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_apb;

  // ---------------------------------------------------------------- stage 2
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_out;
  logic             r_s2_br;
  logic             r_s2_apb;
  logic             r_s2_zf;
  logic             r_s2_cf;
  logic             r_s2_vf;

  // Handshake: stage 2 may load when it is empty or its result is leaving;
  // stage 1 follows stage 2, so a full pipe still accepts an op whenever the
  // consumer takes a result in the same cycle.
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_xfer;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = w_s2_adv;
  assign bus.in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_xfer    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_apb   <= 1'b0;
    end else if (bus.in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (w_in_xfer) begin
        r_s1_op  <= bus.alufn[2:0];
        r_s1_a   <= bus.ra;
        r_s1_b   <= bus.rb_or_imm;
        r_s1_apb <= bus.apb_op;
      end
    end
  end

  // ------------------------------------------------------------ execute
  // One extra bit on both the sum and the difference: the top bit is the
  // carry out for adds and the borrow for subtracts.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_vf;
  logic             w_sub_vf;
  logic [WIDTH-1:0] w_res;
  logic             w_cf;
  logic             w_vf;
  logic             w_br;
  logic [WIDTH-1:0] w_final;

  assign w_sum    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff   = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_add_vf = (r_s1_a[c_msb] == r_s1_b[c_msb]) && (w_sum[c_msb]  != r_s1_a[c_msb]);
  assign w_sub_vf = (r_s1_a[c_msb] != r_s1_b[c_msb]) && (w_diff[c_msb] != r_s1_a[c_msb]);

  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    w_cf  = 1'b0;
    w_vf  = 1'b0;
    w_br  = 1'b0;
    if (r_s1_apb) begin
      // Address generation ignores the opcode entirely.
      w_res = w_sum[WIDTH-1:0];
      w_cf  = w_sum[WIDTH];
      w_vf  = w_add_vf;
    end else begin
      case (r_s1_op)
        c_op_add, c_op_addi, c_op_lw, c_op_sw: begin
          w_res = w_sum[WIDTH-1:0];
          w_cf  = w_sum[WIDTH];
          w_vf  = w_add_vf;
        end
        c_op_sub, c_op_beq: begin
          w_res = w_diff[WIDTH-1:0];
          w_cf  = !w_diff[WIDTH];        // no borrow <=> ra >= rb unsigned
          w_vf  = w_sub_vf;
          w_br  = (r_s1_op == c_op_beq) && (r_s1_a == r_s1_b);
        end
        c_op_and: w_res = r_s1_a & r_s1_b;
        c_op_or:  w_res = r_s1_a | r_s1_b;
        default:  w_res = w_sum[WIDTH-1:0];
      endcase
    end
  end

`ifdef ALU_SAT_EN
  // Only plain ADD/ADDI/SUB clamp; memory address ops, BEQ and APB
  // addresses must keep their wrapped value. On overflow the true result
  // has the sign of ra (both operands agree for add; for sub the sign of ra
  // is the dominant one), so ra's MSB picks the clamp direction.
  localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_sat_ok;
  assign w_sat_ok = !r_s1_apb &&
                    ((r_s1_op == c_op_add) || (r_s1_op == c_op_addi) ||
                     (r_s1_op == c_op_sub));
  assign w_final  = (w_sat_ok && w_vf) ? (r_s1_a[c_msb] ? c_sat_min : c_sat_max)
                                       : w_res;
`else
  assign w_final = w_res;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_out   <= '0;
      r_s2_br    <= 1'b0;
      r_s2_apb   <= 1'b0;
      r_s2_zf    <= 1'b0;
      r_s2_cf    <= 1'b0;
      r_s2_vf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_out <= w_final;
        r_s2_br  <= w_br;
        r_s2_apb <= r_s1_apb;
        r_s2_zf  <= (w_final == '0);
        r_s2_cf  <= w_cf;
        r_s2_vf  <= w_vf;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.aluout    = r_s2_out;
  assign bus.br        = r_s2_br;
  assign bus.apb_req   = r_s2_apb;
  assign bus.zf        = r_s2_zf;
  assign bus.cf        = r_s2_cf;
  assign bus.vf        = r_s2_vf;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe. An 8-bit instance runs a
//                table of hand-computed vectors plus reset sequences; a 16-bit
//                instance runs streaming/backpressure sequences against a
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8),  .OPW(3)) bus8 ();
  alu_pipe_if #(.WIDTH(16), .OPW(3)) bus16 ();

  alu_pipe #(.WIDTH(8),  .OPW(3)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_pipe #(.WIDTH(16), .OPW(3)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ 8-bit table
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       apb;
    logic [7:0] out;
    logic       br;
    logic       ap;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs [16];

  // ------------------------------------------------------ 16-bit reference
  typedef struct packed {
    logic [15:0] out;
    logic        br;
    logic        ap;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  function automatic exp_t model16(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic apb);
    exp_t   e;
    longint ua, ub, sa, sb, t, s;
    bit     arith, sat;
    e     = '0;
    ua    = longint'(a);
    ub    = longint'(b);
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    t     = 0;
    s     = 0;
    arith = 1'b1;
    sat   = 1'b0;
    if (apb || op == 3'd0 || op == 3'd4 || op == 3'd5 || op == 3'd6) begin
      t   = ua + ub;
      s   = sa + sb;
      e.c = (t > 65535);
      sat = !apb && (op == 3'd0 || op == 3'd4);
    end else if (op == 3'd1 || op == 3'd7) begin
      t    = ua - ub;
      s    = sa - sb;
      e.c  = (ua >= ub);
      sat  = (op == 3'd1);
      e.br = (op == 3'd7) && (ua == ub);
    end else begin
      arith = 1'b0;
      t     = (op == 3'd2) ? (ua & ub) : (ua | ub);
    end
    e.v   = arith && (s > 32767 || s < -32768);
    e.out = t[15:0];
`ifdef ALU_SAT_EN
    if (sat && e.v) e.out = (s > 0) ? 16'h7FFF : 16'h8000;
`else
    if (sat && e.v) e.out = t[15:0];
`endif
    e.z  = (e.out == 16'h0000);
    e.ap = apb;
    return e;
  endfunction

  task automatic idle_inputs();
    bus8.in_valid   = 1'b0;  bus8.alufn  = '0; bus8.ra  = '0; bus8.rb_or_imm  = '0;
    bus8.apb_op     = 1'b0;  bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;  bus16.alufn = '0; bus16.ra = '0; bus16.rb_or_imm = '0;
    bus16.apb_op    = 1'b0;  bus16.out_ready = 1'b1;
  endtask

  task automatic drive8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic apb);
    bus8.alufn = op; bus8.ra = a; bus8.rb_or_imm = b; bus8.apb_op = apb;
    bus8.in_valid = 1'b1;
  endtask

  task automatic check_out8(input string tag, input vec_t v);
    check({tag, " out_valid"}, bus8.out_valid, 1);
    check({tag, " aluout"},    bus8.aluout,    v.out);
    check({tag, " br"},        bus8.br,        v.br);
    check({tag, " apb_req"},   bus8.apb_req,   v.ap);
    check({tag, " zf"},        bus8.zf,        v.z);
    check({tag, " cf"},        bus8.cf,        v.c);
    check({tag, " vf"},        bus8.vf,        v.v);
  endtask

  // mode 0: 6 ops, out_ready low for 3 cycles mid-stream
  // mode 1: pipe filled, then out_ready toggling every cycle
  task automatic run_stream(input int n_ops, input int mode);
    exp_t        q[$];
    exp_t        e;
    logic [2:0]  ops_op [32];
    logic [15:0] ops_a  [32];
    logic [15:0] ops_b  [32];
    logic        ops_p  [32];
    int          sent = 0, got = 0, cyc = 0, win_rdy = 0, win_xfer = 0;
    bit          stalled = 1'b0, saw_block = 1'b0, in_win;
    logic [15:0] snap_out = '0;
    logic [5:0]  snap_flg = '0;
    for (int i = 0; i < n_ops; i++) begin
      ops_op[i] = 3'($urandom_range(7));
      ops_a[i]  = 16'($urandom);
      ops_b[i]  = 16'($urandom);
      ops_p[i]  = ($urandom_range(3) == 0);
    end
    if (mode == 0) begin
      // make sure an overflowing add sits in the stalled slot
      ops_op[1] = 3'd0; ops_a[1] = 16'h7FFF; ops_b[1] = 16'h0001; ops_p[1] = 1'b0;
    end
    while (got < n_ops && cyc < 400) begin
      @(posedge clk); #1;
      if (stalled) begin
        check("hold aluout", bus16.aluout, snap_out);
        check("hold flags", {bus16.out_valid, bus16.br, bus16.apb_req, bus16.zf,
                             bus16.cf, bus16.vf}, snap_flg);
      end
      if (mode == 0) bus16.out_ready = !(cyc >= 3 && cyc < 6);
      else           bus16.out_ready = (cyc < 3) ? 1'b0 : ((cyc < 23) ? 1'(cyc % 2) : 1'b1);
      in_win = (mode == 1) && (cyc >= 3) && (cyc < 23);
      if (sent < n_ops) begin
        bus16.alufn = ops_op[sent]; bus16.ra = ops_a[sent];
        bus16.rb_or_imm = ops_b[sent]; bus16.apb_op = ops_p[sent];
        bus16.in_valid = 1'b1;
      end else begin
        bus16.in_valid = 1'b0;
      end
      #1;
      if (!bus16.in_ready) saw_block = 1'b1;
      if (in_win && bus16.out_ready) win_rdy++;
      if (bus16.out_valid && bus16.out_ready) begin
        if (q.size() == 0) begin
          check("spurious output", 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("stream r%0d aluout", got), bus16.aluout, e.out);
          check($sformatf("stream r%0d flags", got),
                {bus16.br, bus16.apb_req, bus16.zf, bus16.cf, bus16.vf},
                {e.br, e.ap, e.z, e.c, e.v});
        end
        got++;
        if (in_win) win_xfer++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        q.push_back(model16(ops_op[sent], ops_a[sent], ops_b[sent], ops_p[sent]));
        sent++;
      end
      stalled  = bus16.out_valid && !bus16.out_ready;
      snap_out = bus16.aluout;
      snap_flg = {bus16.out_valid, bus16.br, bus16.apb_req, bus16.zf, bus16.cf, bus16.vf};
      cyc++;
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    check($sformatf("stream m%0d results", mode), got, n_ops);
    check($sformatf("stream m%0d accepted", mode), sent, n_ops);
    if (mode == 0) check("in_ready dropped", saw_block, 1);
    else           check("throughput", win_xfer, win_rdy);
  endtask

  initial begin
    //                op    a      b      apb   out    br ap z  c  v
    vecs[0]  = '{3'd0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SAT_EN
    vecs[1]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    vecs[1]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    vecs[2]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SAT_EN
    vecs[4]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    vecs[4]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 8'h05, 8'hFB, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{3'd5, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'd6, 8'h20, 8'h10, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 8'h5A, 8'h5B, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'd7, 8'h40, 8'h04, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'd1, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{3'd7, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // ---------------------------------------------------------- reset state
    idle_inputs();
    rst = 1'b1;
    #2;
    check("reset out_valid", bus8.out_valid, 0);
    check("reset outputs", {bus8.aluout, bus8.br, bus8.apb_req, bus8.zf, bus8.cf, bus8.vf}, 0);
    check("reset out_valid w16", bus16.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after reset", bus8.in_ready, 1);
    check("in_ready after reset w16", bus16.in_ready, 1);

    // ---------------------------------------------------------- vector table
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].apb);
      #1 check($sformatf("v%0d in_ready", i), bus8.in_ready, 1);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      check($sformatf("v%0d early out_valid", i), bus8.out_valid, 0);
      @(posedge clk); #1;
      check_out8($sformatf("v%0d", i), vecs[i]);
    end

    // ------------------------------------------- async reset with ops in flight
    @(posedge clk); #1;
    drive8(3'd0, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    drive8(3'd3, 8'h0F, 8'hF0, 1'b0);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    check("flight out_valid", bus8.out_valid, 1);
    check("flight aluout", bus8.aluout, 8'h46);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", bus8.out_valid, 0);
    check("async rst outputs", {bus8.aluout, bus8.br, bus8.apb_req, bus8.zf, bus8.cf, bus8.vf}, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("discarded op c%0d", i), bus8.out_valid, 0);
    end
    drive8(3'd6, 8'h20, 8'h10, 1'b0);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    check("post-rst early out_valid", bus8.out_valid, 0);
    @(posedge clk); #1;
    check_out8("post-rst", vecs[10]);

    // -------------------------------------------------- 16-bit streaming
    run_stream(6, 0);
    repeat (3) @(posedge clk);
    run_stream(24, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so a wedged handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the single-cycle 8-bit ALU in the core datapath. Accepts one operation per cycle over a valid/ready handshake and returns result, branch flag and status flags two cycles later, with full output backpressure. When apb_op is set, the block computes an APB transfer address for the I2C/APB bridge instead of the normal ALU result.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 4).
OPW, 3, opcode width; opcode encodings below are fixed in the low 3 bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operation present on inputs.
in_ready  output  1  block can accept an operation this cycle.
alufn  input  OPW  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADDI, 101 LW, 110 SW, 111 BEQ.
ra  input  WIDTH  operand A.
rb_or_imm  input  WIDTH  operand B or immediate.
apb_op  input  1  APB address-generation request.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
aluout  output  WIDTH  result.
br  output  1  BEQ taken.
apb_req  output  1  result is an APB address.
zf  output  1  result zero.
cf  output  1  carry out (ADD-class) / no-borrow (SUB).
vf  output  1  signed overflow (ADD-class, SUB).

Behaviour:
- Reset (async, rst=1): every stage valid bit cleared; out_valid=0, aluout=0, br=0, apb_req=0, zf=0, cf=0, vf=0. in_ready=1 from the first cycle after rst deasserts.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage 1 registers opcode, operands and apb_op. Stage 2 registers the computed result and flags; stage 2 drives the outputs directly, with no combinational path from inputs.
- Latency: exactly 2 cycles from input transfer to out_valid with no stalls; throughput 1 op/cycle.
- Backpressure: stage 2 holds while out_valid & !out_ready. Stage 1 advances whenever stage 2 is empty or transferring. in_ready = !s1_valid | s1_advance. All held outputs stay stable and unchanged while stalled. No op is dropped or duplicated.
- Arithmetic: computed at WIDTH+1 bits. ADD, ADDI, LW and SW compute ra+rb. SUB computes ra-rb with cf = (ra >= rb unsigned). AND and OR are bitwise; for these, cf=0 and vf=0.
- vf: ADD-class sets it when both operand MSBs are equal and the result MSB differs. SUB sets it when the operand MSBs differ and the result MSB differs from ra's MSB.
- zf = (aluout == 0) for all ops.
- BEQ: br = (ra == rb_or_imm); aluout = ra - rb_or_imm; flags as SUB. br=0 for every other op.
- apb_op=1 overrides alufn: aluout = ra + rb_or_imm, apb_req=1, br=0, flags as ADD. apb_req=0 otherwise.
- Wrap-around: results are truncated to WIDTH bits, e.g. 0xFF+0x01 gives 0x00 with cf=1 and zf=1.
- Simultaneous full pipe, input transfer and output transfer: all three happen in the same cycle.
- rst asserted mid-operation: all in-flight ops are discarded immediately and outputs return to reset values.

Optional Feature:
ALU_SAT_EN:
- Defined: ADD, ADDI and SUB saturate as signed values. On vf=1, aluout = 0x7F..F if the true result is positive, or 0x80..0 if negative. vf is still reported. LW, SW, BEQ and apb_op paths never saturate.
- Undefined: all ops wrap modulo 2^WIDTH and saturation logic is absent.

Test Plan:
- Reset then ADD ra=0x12, rb=0x34 with out_ready=1 -> out_valid two cycles after transfer; aluout=0x46, zf=0, cf=0, vf=0, br=0.
- ADD 0x7F+0x01 -> aluout=0x80, vf=1, cf=0. With ALU_SAT_EN: aluout=0x7F, vf=1. ADD 0xFF+0x01 -> aluout=0x00, zf=1, cf=1, and no saturation in either build.
- BEQ 0x5A,0x5A -> br=1, zf=1, aluout=0x00. BEQ 0x5A,0x5B -> br=0, cf=0. Then apb_op=1 with alufn=111, ra=0x40, rb=0x04 -> aluout=0x44, apb_req=1, br=0.
- Back-to-back stream of 6 ops with out_ready held 0 for 3 cycles mid-stream -> in_ready drops once both stages are full; outputs stay stable while stalled; all 6 results arrive in order with none lost or duplicated.
- Pipe full and out_ready toggling every cycle, with random ops at WIDTH=16 -> results match the reference model and throughput equals the number of out_ready=1 cycles.
- rst pulsed while 2 ops are in flight -> out_valid and all outputs are 0 immediately (asynchronously); a new op after release completes with normal 2-cycle latency.
